// File: rtl/player_input_pkg.sv
// player_input_pkg: shared event kind enum, sizing helpers and the default-size
// event record exchanged between player_input_hub and singleprocessor.
package player_input_pkg;

  typedef enum logic {
    EVT_PRESS   = 1'b0,
    EVT_RELEASE = 1'b1
  } evt_kind_e;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DROP_W = 8;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Record layout at default sizing (2 players, 360x720 canvas); the hub
  // builds a width-matched local copy with the same field order.
  localparam int unsigned DEF_PW = 1;
  localparam int unsigned DEF_XW = 9;
  localparam int unsigned DEF_YW = 10;

  typedef struct packed {
    logic [DEF_PW-1:0] player;
    evt_kind_e         kind;
    logic [DEF_XW-1:0] x;
    logic [DEF_YW-1:0] y;
  } evt_rec_t;

endpackage

// File: rtl/player_input_hub_if.sv
// player_input_hub_if: ready/valid event stream from the hub to its consumer.
interface player_input_hub_if #(
  parameter int unsigned PW = 1,
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 10
);
  import player_input_pkg::*;

  logic          evt_valid;
  logic          evt_ready;
  logic [PW-1:0] evt_player;
  evt_kind_e     evt_kind;
  logic [XW-1:0] evt_x;
  logic [YW-1:0] evt_y;

  modport master (
    output evt_valid, evt_player, evt_kind, evt_x, evt_y,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_player, evt_kind, evt_x, evt_y,
    output evt_ready
  );

endinterface

// File: rtl/event_fifo.sv
// event_fifo: first-word-fall-through FIFO of packed event records.
module event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic [7:0]
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_push,
  input  T     i_wdata,
  input  logic i_pop,
  output T     o_rdata,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  T             r_mem [DEPTH];
  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;

  // Storage and pointers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wp[AW-1:0]] <= i_wdata;
        r_wp                <= r_wp + (AW+1)'(1);
      end
      if (i_pop) begin
        r_rp <= r_rp + (AW+1)'(1);
      end
    end
  end

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_rdata = r_mem[r_rp[AW-1:0]];

endmodule

// File: rtl/player_input_hub.sv
// player_input_hub: per-player cursor clamp, click debounce and press capture,
// serialised round-robin into one event FIFO.
// Optional feature: define RELEASE_EVENTS_EN to also emit release (kind=1) events.
module player_input_hub
  import player_input_pkg::*;
#(
  parameter  int unsigned NUM_PLAYERS   = 2,
  parameter  int unsigned CANVAS_WIDTH  = 360,
  parameter  int unsigned CANVAS_HEIGHT = 720,
  parameter  int unsigned HOLD_CYCLES   = 4,
  parameter  int unsigned FIFO_DEPTH    = 8,
  localparam int unsigned XW            = $clog2(CANVAS_WIDTH),
  localparam int unsigned YW            = $clog2(CANVAS_HEIGHT),
  localparam int unsigned PW            = idx_w(NUM_PLAYERS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_PLAYERS*XW-1:0] mouse_x,
  input  logic [NUM_PLAYERS*YW-1:0] mouse_y,
  input  logic [NUM_PLAYERS-1:0]    click,
  output logic [NUM_PLAYERS*XW-1:0] cursor_x,
  output logic [NUM_PLAYERS*YW-1:0] cursor_y,
  output logic [NUM_PLAYERS-1:0]    held,
  output logic [DROP_W-1:0]         drop_count,
  player_input_hub_if.master        evt
);

  typedef struct packed {
    logic [PW-1:0] player;
    evt_kind_e     kind;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } hub_rec_t;

  logic [NUM_PLAYERS-1:0]    r_click;
  logic [NUM_PLAYERS*XW-1:0] r_cx;
  logic [NUM_PLAYERS*YW-1:0] r_cy;
  logic [NUM_PLAYERS*XW-1:0] w_cx;
  logic [NUM_PLAYERS*YW-1:0] w_cy;
  logic [CNT_W-1:0]          r_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]    r_held;
  logic [NUM_PLAYERS-1:0]    r_held_d;
  logic [NUM_PLAYERS-1:0]    w_rise;
  logic [NUM_PLAYERS-1:0]    w_evt;
  evt_kind_e                 w_kind [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]    r_pend;
  evt_kind_e                 r_pkind [NUM_PLAYERS];
  logic [XW-1:0]             r_px [NUM_PLAYERS];
  logic [YW-1:0]             r_py [NUM_PLAYERS];
  logic [PW-1:0]             r_rr;
  logic [PW-1:0]             w_idx;
  logic [PW-1:0]             w_gnt;
  logic                      w_gnt_vld;
  logic [NUM_PLAYERS-1:0]    w_gnt_oh;
  logic                      w_ovr;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_full_drop;
  logic [DROP_W-1:0]         r_drop;
  hub_rec_t                  w_rec;
  hub_rec_t                  w_head;

  // Clamp raw coordinates to the canvas.
  always_comb begin
    w_cx = '0;
    w_cy = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      w_cx[p*XW +: XW] = (mouse_x[p*XW +: XW] > XW'(CANVAS_WIDTH - 1))
                         ? XW'(CANVAS_WIDTH - 1) : mouse_x[p*XW +: XW];
      w_cy[p*YW +: YW] = (mouse_y[p*YW +: YW] > YW'(CANVAS_HEIGHT - 1))
                         ? YW'(CANVAS_HEIGHT - 1) : mouse_y[p*YW +: YW];
    end
  end

  // Input register stage for clicks and clamped cursors.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_click <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
    end else begin
      r_click <= click;
      r_cx    <= w_cx;
      r_cy    <= w_cy;
    end
  end

  // Debounce: held follows the registered click after HOLD_CYCLES of disagreement.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_held   <= '0;
      r_held_d <= '0;
      for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
        r_cnt[p] <= '0;
      end
    end else begin
      r_held_d <= r_held;
      for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
        if (r_click[p] == r_held[p]) begin
          r_cnt[p] <= '0;
        end else if (r_cnt[p] == CNT_W'(HOLD_CYCLES - 1)) begin
          r_held[p] <= ~r_held[p];
          r_cnt[p]  <= '0;
        end else begin
          r_cnt[p] <= r_cnt[p] + CNT_W'(1);
        end
      end
    end
  end

  // Edge detection on the debounced level.
  always_comb begin
    w_rise = r_held & ~r_held_d;
`ifdef RELEASE_EVENTS_EN
    w_evt  = w_rise | (~r_held & r_held_d);
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      w_kind[p] = w_rise[p] ? EVT_PRESS : EVT_RELEASE;
    end
`else
    w_evt  = w_rise;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      w_kind[p] = EVT_PRESS;
    end
`endif
  end

  // Round-robin pick starting at the pointer.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_gnt_oh  = '0;
    w_idx     = '0;
    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
      w_idx = PW'((int'(r_rr) + i) % int'(NUM_PLAYERS));
      if (!w_gnt_vld && r_pend[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
    if (w_gnt_vld) begin
      w_gnt_oh[w_gnt] = 1'b1;
    end
  end

  // Pending capture; a fresh event wins over a same-cycle grant clear.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pend <= '0;
      r_rr   <= '0;
      for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
        r_pkind[p] <= EVT_PRESS;
        r_px[p]    <= '0;
        r_py[p]    <= '0;
      end
    end else begin
      for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
        if (w_evt[p]) begin
          r_pend[p]  <= 1'b1;
          r_pkind[p] <= w_kind[p];
          r_px[p]    <= r_cx[p*XW +: XW];
          r_py[p]    <= r_cy[p*YW +: YW];
        end else if (w_gnt_oh[p]) begin
          r_pend[p] <= 1'b0;
        end
      end
      if (w_gnt_vld) begin
        r_rr <= (w_gnt == PW'(NUM_PLAYERS - 1)) ? '0 : w_gnt + PW'(1);
      end
    end
  end

  // FIFO write/pop control and loss detection.
  always_comb begin
    w_rec.player = w_gnt;
    w_rec.kind   = r_pkind[w_gnt];
    w_rec.x      = r_px[w_gnt];
    w_rec.y      = r_py[w_gnt];
    w_pop        = ~w_empty & evt.evt_ready;
    w_push       = w_gnt_vld & (~w_full | w_pop);
    w_full_drop  = w_gnt_vld & w_full & ~w_pop;
    w_ovr        = |(w_evt & r_pend & ~w_gnt_oh);
  end

  // Saturating loss counter, at most one step per cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_drop <= '0;
    end else if ((w_ovr || w_full_drop) && (r_drop != {DROP_W{1'b1}})) begin
      r_drop <= r_drop + DROP_W'(1);
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (hub_rec_t)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (w_push),
    .i_wdata (w_rec),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cursor_x       = r_cx;
  assign cursor_y       = r_cy;
  assign held           = r_held;
  assign drop_count     = r_drop;
  assign evt.evt_valid  = ~w_empty;
  assign evt.evt_player = w_head.player;
  assign evt.evt_kind   = w_head.kind;
  assign evt.evt_x      = w_head.x;
  assign evt.evt_y      = w_head.y;

endmodule
